clkdet: RTL and testbench

CLKDET -- requirements
Module: clkdet

---
 rtl/clkdet_pkg.sv | 21 ++
 rtl/clkdet_sync.sv | 38 +++
 rtl/clkdet.sv | 173 +++++++++++++++++
 tb/tb_clkdet.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdet_pkg.sv
// Shared types and constants for the CLKDET clock-divisor detector.
package clkdet_pkg;

  localparam int HALF_MAX = 32;
  localparam int CNT_W    = 8;
  localparam int MATCH_W  = 4;
  localparam int CAND_W   = 6;
  localparam int DIV_W    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_e;

  // A measured half-period is usable only inside the divider's code range.
  function automatic logic half_valid(input logic [CNT_W-1:0] h);
    return (h != '0) && (h <= CNT_W'(HALF_MAX));
  endfunction

endpackage

// File: rtl/clkdet_sync.sv
// Synchronizer and edge detector for the asynchronous CLKSRC input; the
// rise/fall strobes are registered, so they appear SYNC_STAGES+1 cycles after CLKSRC moves.
module clkdet_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/clkdet.sv
// CLKDET: measures CLKSRC half-periods in CLKIN cycles and recovers the divisor code.
// Build option: define CLKDET_EDGE_STROBE_EN to drive the RISE/FALL strobes (tied 0 otherwise).
module clkdet
  import clkdet_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic             CLKIN,
  input  logic             RESETn,
  input  logic             CLKSRC,
  input  logic             ERR_CLR,
  output logic [DIV_W-1:0] DIV,
  output logic             LOCKED,
  output logic             ERR,
  output logic             RISE,
  output logic             FALL
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [CAND_W-1:0]    cand_q, cand_d;
  logic                 cand_vld_q, cand_vld_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;

  logic                 sync_level_unused;
  logic                 rise_w, fall_w, edge_w;
  logic                 h_valid, h_match, lock_hit, timeout_w;
  logic                 reload, err_set;
  logic [MATCH_W-1:0]   match_inc;

  clkdet_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (CLKIN),
    .rst_n  (RESETn),
    .src_i  (CLKSRC),
    .level_o(sync_level_unused),
    .rise_o (rise_w),
    .fall_o (fall_w)
  );

  assign edge_w = rise_w | fall_w;

  // cnt_q at an edge is the half-period just measured.
  assign h_valid   = half_valid(cnt_q);
  assign h_match   = cand_vld_q & h_valid & (cnt_q == {2'b00, cand_q});
  assign match_inc = match_q + MATCH_W'(1);
  assign lock_hit  = h_match & (match_inc == MATCH_W'(LOCK_CNT));
  assign timeout_w = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLKIN or negedge RESETn) begin
    if (!RESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Timeout is only considered in cycles without an edge, so an edge always wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (edge_w) state_d = ACQ;
      ACQ: begin
        if (edge_w) begin
          if (lock_hit) state_d = LOCK;
        end else if (timeout_w) begin
          state_d = IDLE;
        end
      end
      LOCK: begin
        if (edge_w) begin
          if (!h_match) state_d = ACQ;
        end else if (timeout_w) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every _d starts from its hold value so no branch can infer a latch.
    cnt_d      = edge_w ? CNT_W'(1)
               : (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    match_d    = match_q;
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    div_d      = div_q;
    locked_d   = locked_q;
    reload     = 1'b0;
    err_set    = 1'b0;

    case (state_q)
      IDLE: begin
        if (edge_w) begin
          match_d    = '0;
          cand_d     = '0;
          cand_vld_d = 1'b0;
        end
      end
      ACQ: begin
        if (edge_w) begin
          if (h_match) begin
            match_d = match_inc;
            if (lock_hit) begin
              div_d    = DIV_W'(cand_q - CAND_W'(1));
              locked_d = 1'b1;
            end
          end else begin
            reload = 1'b1;
          end
        end
      end
      LOCK: begin
        if (edge_w) begin
          if (!h_match) begin
            err_set  = 1'b1;
            locked_d = 1'b0;
            reload   = 1'b1;
          end
        end else if (timeout_w) begin
          locked_d = 1'b0;
        end
      end
      default: ;
    endcase

    // A fresh measurement becomes the candidate; an out-of-range one leaves none.
    if (reload) begin
      cand_d     = h_valid ? CAND_W'(cnt_q) : '0;
      cand_vld_d = h_valid;
      match_d    = h_valid ? MATCH_W'(1) : '0;
    end

    err_d = err_set | (err_q & ~ERR_CLR);
  end

  always_ff @(posedge CLKIN or negedge RESETn) begin
    if (!RESETn) begin
      cnt_q      <= '0;
      match_q    <= '0;
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
      div_q      <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      match_q    <= match_d;
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
      div_q      <= div_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign DIV    = div_q;
  assign LOCKED = locked_q;
  assign ERR    = err_q;

`ifdef CLKDET_EDGE_STROBE_EN
  assign RISE = rise_w;
  assign FALL = fall_w;
`else
  assign RISE = 1'b0;
  assign FALL = 1'b0;
`endif

endmodule

// File: tb/tb_clkdet.sv
// Self-checking bench for clkdet: directed CLKSRC patterns, a half-period model
// compared every cycle, and hand-computed lock/timeout/error expectations.
`timescale 1ns/1ps
module tb_clkdet;

  localparam int SYNC_STAGES = 2;
  localparam int LOCK_CNT    = 4;
  localparam int TIMEOUT     = 64;
`ifdef CLKDET_EDGE_STROBE_EN
  localparam bit STROBE_EN = 1'b1;
`else
  localparam bit STROBE_EN = 1'b0;
`endif

  logic       CLKIN   = 1'b0;
  logic       RESETn  = 1'b0;
  logic       CLKSRC  = 1'b0;
  logic       ERR_CLR = 1'b0;
  logic [4:0] DIV;
  logic       LOCKED, ERR, RISE, FALL;

  int checks = 0;
  int errors = 0;

  clkdet #(
    .SYNC_STAGES(SYNC_STAGES),
    .LOCK_CNT   (LOCK_CNT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .CLKIN  (CLKIN),
    .RESETn (RESETn),
    .CLKSRC (CLKSRC),
    .ERR_CLR(ERR_CLR),
    .DIV    (DIV),
    .LOCKED (LOCKED),
    .ERR    (ERR),
    .RISE   (RISE),
    .FALL   (FALL)
  );

  always #5 CLKIN = ~CLKIN;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit sq[$];          // CLKSRC samples at each CLKIN rise, newest first
  bit m_init = 1'b0;
  int m_state;        // 0 idle, 1 acquiring, 2 locked
  int m_cand, m_match, m_cyc, m_last_edge;
  bit m_cand_ok;
  int e_div;
  bit e_locked, e_err, e_rise, e_fall;

  task automatic model_reset();
    sq.delete();
    for (int i = 0; i < SYNC_STAGES + 3; i++) sq.push_back(1'b0);
    m_state = 0; m_cand = 0; m_match = 0; m_cand_ok = 1'b0;
    m_last_edge = m_cyc;
    e_div = 0; e_locked = 1'b0; e_err = 1'b0; e_rise = 1'b0; e_fall = 1'b0;
    m_init = 1'b1;
  endtask

  task automatic model_step();
    int h;
    bit ev, ok, hit;
    m_cyc++;
    h = m_cyc - m_last_edge;
    if (h > 255) h = 255;
    sq.push_front(CLKSRC);
    void'(sq.pop_back());
    // The detector reacts to a CLKSRC change SYNC_STAGES+1 cycles after it is sampled.
    ev = (sq[SYNC_STAGES+1] != sq[SYNC_STAGES+2]);
    e_rise = STROBE_EN && sq[SYNC_STAGES] && !sq[SYNC_STAGES+1];
    e_fall = STROBE_EN && !sq[SYNC_STAGES] && sq[SYNC_STAGES+1];
    if (ERR_CLR) e_err = 1'b0;
    ok  = (h >= 1) && (h <= 32);
    hit = ok && m_cand_ok && (h == m_cand);
    if (ev) begin
      m_last_edge = m_cyc;
      if (m_state == 0) begin
        m_state = 1; m_match = 0; m_cand_ok = 1'b0; m_cand = 0;
      end else if (hit) begin
        if (m_state == 1) begin
          m_match++;
          if (m_match == LOCK_CNT) begin
            m_state = 2; e_div = m_cand - 1; e_locked = 1'b1;
          end
        end
      end else begin
        if (m_state == 2) begin
          e_err = 1'b1; e_locked = 1'b0; m_state = 1;
        end
        m_cand = ok ? h : 0; m_cand_ok = ok; m_match = ok ? 1 : 0;
      end
    end else if (m_state != 0 && h + 1 == TIMEOUT) begin
      // the half-period counter reaches TIMEOUT on this clock
      m_state = 0; e_locked = 1'b0;
    end
  endtask

  always @(posedge CLKIN or negedge RESETn) begin
    if (!RESETn) model_reset();
    else         model_step();
  end

  always @(negedge CLKIN) begin
    if (RESETn && m_init) begin
      check("div",    32'(DIV),    32'(e_div));
      check("locked", 32'(LOCKED), 32'(e_locked));
      check("err",    32'(ERR),    32'(e_err));
      check("rise",   32'(RISE),   32'(e_rise));
      check("fall",   32'(FALL),   32'(e_fall));
    end
  end

  // ---------------- stimulus helpers ----------------
  int slack = 0;  // negedges already spent since the last CLKSRC toggle

  task automatic half(input int n);
    repeat (n - slack) @(negedge CLKIN);
    CLKSRC = ~CLKSRC;
    slack = 0;
  endtask

  task automatic wait_to(input int k);
    repeat (k - slack) @(negedge CLKIN);
    slack = k;
  endtask

  // LOCKED one cycle before and on the cycle the last toggle's edge is acted on.
  task automatic probe(input string nm, input logic exp_pre, input logic exp_post,
                       input logic [4:0] exp_div);
    wait_to(3);
    check({nm, "_pre"}, 32'(LOCKED), 32'(exp_pre));
    wait_to(4);
    check({nm, "_post"}, 32'(LOCKED), 32'(exp_post));
    if (exp_post) check({nm, "_div"}, 32'(DIV), 32'(exp_div));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLKIN);
    check("rst_div",    32'(DIV),    0);
    check("rst_locked", 32'(LOCKED), 0);
    check("rst_err",    32'(ERR),    0);
    check("rst_rise",   32'(RISE),   0);
    check("rst_fall",   32'(FALL),   0);
    #2 RESETn = 1'b1;
    @(negedge CLKIN);
    slack = 0;

    // Lock on half-period 4: IDLE edge, one out-of-range gap, four matches.
    half(4);
    half(40);
    half(4); half(4);
    half(4);
    probe("lock4_5th", 1'b0, 1'b0, 5'd0);
    half(4);
    wait_to(3);
    check("lock4_fall", 32'(FALL), 32'(STROBE_EN));
    check("lock4_rise", 32'(RISE), 0);
    probe("lock4_6th", 1'b0, 1'b1, 5'd3);
    check("lock4_err", 32'(ERR), 0);
    repeat (3) half(4);

    // Switch to half-period 6: error, loss of lock, relock at DIV 5.
    half(6);
    wait_to(3);
    check("sw6_err_pre", 32'(ERR), 0);
    wait_to(4);
    check("sw6_err", 32'(ERR), 1);
    check("sw6_locked", 32'(LOCKED), 0);
    half(6); half(6);
    half(6);
    probe("relock6", 1'b0, 1'b1, 5'd5);
    check("sticky_err", 32'(ERR), 1);
    wait_to(5);
    ERR_CLR = 1'b1;
    half(6);
    ERR_CLR = 1'b0;
    wait_to(1);
    check("err_clr", 32'(ERR), 0);

    // ERR_CLR coinciding with a mismatch edge: the set wins.
    half(4);
    wait_to(3);
    check("clr_vs_set_pre", 32'(ERR), 0);
    ERR_CLR = 1'b1;
    wait_to(4);
    ERR_CLR = 1'b0;
    check("clr_vs_set", 32'(ERR), 1);
    check("clr_vs_set_lk", 32'(LOCKED), 0);
    half(4); half(4);
    half(4);
    probe("relock4", 1'b0, 1'b1, 5'd3);

    // CLKSRC stops: lock drops 64 cycles after the last synced edge.
    wait_to(66);
    check("to_before", 32'(LOCKED), 1);
    wait_to(67);
    check("to_locked", 32'(LOCKED), 0);
    check("to_div", 32'(DIV), 3);
    check("to_err", 32'(ERR), 1);
    half(4);
    repeat (2) half(4);
    half(4);
    probe("idle_4th", 1'b0, 1'b0, 5'd0);
    half(4);
    probe("idle_5th", 1'b0, 1'b1, 5'd3);

    // Reset in the middle of acquisition (match = 2).
    wait_to(67);
    half(4); half(4); half(4);
    wait_to(4);
    check("pre_rst_div", 32'(DIV), 3);
    check("pre_rst_err", 32'(ERR), 1);
    @(posedge CLKIN);
    #2 RESETn = 1'b0;
    #1;
    check("arst_div",    32'(DIV),    0);
    check("arst_locked", 32'(LOCKED), 0);
    check("arst_err",    32'(ERR),    0);
    check("arst_rise",   32'(RISE),   0);
    check("arst_fall",   32'(FALL),   0);
    CLKSRC = 1'b0;
    #4 RESETn = 1'b1;
    @(negedge CLKIN);
    slack = 0;
    repeat (3) half(4);
    half(4);
    probe("rst_4th", 1'b0, 1'b0, 5'd0);
    half(4);
    probe("rst_5th", 1'b0, 1'b1, 5'd3);

    // Extremes of the divisor range.
    repeat (10) half(1);
    probe("div0", 1'b1, 1'b1, 5'd0);
    repeat (3) half(32);
    half(32);
    probe("div31", 1'b0, 1'b1, 5'd31);

    // Half-period 33 is out of range and never locks.
    repeat (3) half(33);
    half(33);
    probe("h33", 1'b0, 1'b0, 5'd0);
    check("h33_err", 32'(ERR), 1);
    wait_to(5);
    ERR_CLR = 1'b1;
    wait_to(6);
    ERR_CLR = 1'b0;
    wait_to(7);
    check("h33_clr", 32'(ERR), 0);

    repeat (4) @(negedge CLKIN);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
